arith_narrow: RTL and testbench
===============================

# Arith_narrow

Multi-lane, saturating width-reduction stage with a registered output: the inverse of `Arith_extend`. It narrows `DEPTH` lanes of `IN_W`-bit values to `OUT_W` bits, clamping out-of-range values to the nearest representable limit under signed or unsigned interpretation. It also keeps per-lane sticky clip flags and a saturating clip-event counter. It sits on the ALU/load-store result path wherever a wide intermediate is written to a narrower field.

## Interface
Parameters:
- `IN_W`, 8: input lane width; must be ≥ `OUT_W`.
- `OUT_W`, 4: output lane width; must be ≥ 1.
- `DEPTH`, 2: number of independent lanes.
- `CNT_W`, 8: width of the clip-event counter.

Ports:
- `ctrl`  input  `Util_Control_T`: one clock, `Util_Control_clock(ctrl)`, rising edge. Reset `Util_Control_reset(ctrl)` is synchronous and active-high.
- `in`  input  `[IN_W-1:0]` × `DEPTH`: lane inputs.
- `sign`  input  `Arith_SignedUnsigned_T`: interpretation of inputs and limits, common to all lanes.
- `valid_in`  input  1: capture `in` this cycle.
- `clear`  input  1: clear `sticky` and `clip_count`.
- `out`  output  `[OUT_W-1:0]` × `DEPTH`: narrowed lanes.
- `valid_out`  output  1: `out` holds a result captured last cycle.
- `clip`  output  `[DEPTH-1:0]`: lane was clamped in the current `out`.
- `sticky`  output  `[DEPTH-1:0]`: lane has clipped since the last reset or clear.
- `clip_count`  output  `[CNT_W-1:0]`: number of accepted cycles with any clip, saturating.

## Operation
- Signed mode:
  - Input is two's-complement `IN_W`.
  - Upper limit is 2^(OUT_W-1)−1; lower limit is −2^(OUT_W-1).
  - A value above the upper limit gives the upper limit. A value below the lower limit gives the lower limit.
  - Otherwise the result is the low `OUT_W` bits.
- Unsigned mode:
  - Input is unsigned.
  - A value above 2^OUT_W−1 gives all-ones. Otherwise the result is the low `OUT_W` bits.
- The range test is exact. A lane is in range iff the discarded upper bits are all equal to the kept MSB (signed) or are all zero (unsigned).
- `IN_W == OUT_W`: pass-through; `clip` is never set.
- `valid_in`=0: `out` and `clip` hold their previous values, `valid_out` goes to 0, and the counters do not change.
- Sticky update on each accepted cycle: `sticky` ← (`clear` ? 0 : `sticky`) | new `clip`.
- Counter update on each accepted cycle: `clip_count` ← (`clear` ? 0 : `clip_count`) + (|new `clip`), saturating at 2^CNT_W−1. It never wraps.
- `clear` with `valid_in`=0: `sticky` and `clip_count` go to 0.
- `clear` and a clip in the same cycle: the new clip wins. `sticky` equals the new `clip` and `clip_count` equals 1.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `out`, `clip` and `valid_out` after edge N. The counters update at the same edge.
- Reset values: `out`=0, `valid_out`=0, `clip`=0, `sticky`=0, `clip_count`=0.
- Reset overrides `valid_in` and `clear` in the same cycle.
- Reset mid-stream discards the captured value. The first valid output after release appears one cycle after the first `valid_in`.
- `sign` is sampled together with `in`. A change of `sign` affects only subsequently captured data.
- There is no backpressure: the block accepts a new value every cycle.

## Structure
- `Arith_SignedUnsigned_T` and its constants come from the shared Arith package.
- Add to the shared package a constant function that returns the signed and unsigned limits for a given `OUT_W`.
- Sub-module `Arith_narrow_lane` is combinational: one lane's in-range test, clamp and `clip` bit. It is instantiated `DEPTH` times.
- The top level holds the output registers, the `sticky` register and the counter.

## Test plan
All scenarios use IN_W=8, OUT_W=4, DEPTH=2 unless stated otherwise.
- Reset for 2 cycles, then `valid_in`=0 → all outputs 0. Signed, `in`={8'h7F, 8'hF9} → next cycle `out`={4'h7, 4'h9}, `clip`=2'b01, `sticky`=2'b01, `clip_count`=1.
- Signed, `in`={8'h80, 8'h05} → `out`={4'h8, 4'h5}, `clip`=2'b01. Signed, `in`={8'hF8, 8'h07} → `out`={4'h8, 4'h7}, `clip`=0, count unchanged.
- Unsigned, `in`={8'h0A, 8'h10} → `out`={4'hA, 4'hF}, `clip`=2'b10.
- Unsigned, `in`={8'h10, 8'h00} with `clear`=1 after prior clips → `sticky`=2'b01, `clip_count`=1. Then `clear` alone → `sticky`=0, `clip_count`=0.
- CNT_W=2, 5 consecutive clipping cycles → `clip_count` sequence 1, 2, 3, 3, 3.
- `valid_in`=1 every cycle, then reset asserted for one cycle → all outputs 0. Hold `valid_in`=0 afterwards → `out` stays 0 and `valid_out`=0.

Source files
------------

// File: rtl/arith_narrow_pkg.sv
// Shared definitions for the narrowing stage: control bundle, signedness
// selector and the saturation limits helper.
package arith_narrow_pkg;

  // Clock and reset travel together as one control bundle.
  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;

  function automatic logic Util_Control_clock(input Util_Control_T c);
    return c.clock;
  endfunction

  function automatic logic Util_Control_reset(input Util_Control_T c);
    return c.reset;
  endfunction

  // Interpretation of a lane value.
  typedef enum logic {
    ARITH_UNSIGNED = 1'b0,
    ARITH_SIGNED   = 1'b1
  } Arith_SignedUnsigned_T;

  // Saturation limits, held wide and sliced down to the output width by users.
  typedef struct packed {
    logic [63:0] s_max;
    logic [63:0] s_min;
    logic [63:0] u_max;
  } arith_limits_t;

  // Signed max is 0111..1, signed min is 1000..0, unsigned max is all-ones.
  function automatic arith_limits_t arith_narrow_limits(input int out_w);
    arith_limits_t lim;
    lim.s_max = (64'd1 << (out_w - 1)) - 64'd1;
    lim.s_min = ~lim.s_max;
    lim.u_max = (64'd1 << out_w) - 64'd1;
    return lim;
  endfunction

endpackage

// File: rtl/arith_narrow_lane.sv
// One lane of the narrowing stage: exact range test, clamp and clip flag.
// Purely combinational.
module arith_narrow_lane
  import arith_narrow_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]      in,
  input  Arith_SignedUnsigned_T sign,
  output logic [OUT_W-1:0]     out,
  output logic                 clip
);

  localparam arith_limits_t      LIM   = arith_narrow_limits(OUT_W);
  localparam logic [OUT_W-1:0]   S_MAX = LIM.s_max[OUT_W-1:0];
  localparam logic [OUT_W-1:0]   S_MIN = LIM.s_min[OUT_W-1:0];
  localparam logic [OUT_W-1:0]   U_MAX = LIM.u_max[OUT_W-1:0];

  logic [OUT_W-1:0] low;
  logic [IN_W-1:0]  rebuilt;
  logic             in_range;

  assign low = in[OUT_W-1:0];

  // A value is in range iff re-extending its low bits reproduces the input;
  // this also covers IN_W == OUT_W, where it is always in range.
  always_comb begin
    rebuilt = '0;
    if (sign == ARITH_SIGNED) begin
      rebuilt = IN_W'($signed(low));
    end else begin
      rebuilt = IN_W'(low);
    end
    in_range = (rebuilt == in);
  end

  // Clamp toward the nearest limit on overflow, else keep the low bits.
  always_comb begin
    out = low;
    if (!in_range) begin
      if (sign == ARITH_SIGNED) begin
        out = in[IN_W-1] ? S_MIN : S_MAX;
      end else begin
        out = U_MAX;
      end
    end
  end

  assign clip = ~in_range;

endmodule

// File: rtl/arith_narrow.sv
// Multi-lane saturating width reduction with registered outputs, sticky
// per-lane clip flags and a saturating clip-event counter.
module arith_narrow
  import arith_narrow_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  Util_Control_T                 ctrl,
  input  logic [DEPTH-1:0][IN_W-1:0]    in,
  input  Arith_SignedUnsigned_T         sign,
  input  logic                          valid_in,
  input  logic                          clear,
  output logic [DEPTH-1:0][OUT_W-1:0]   out,
  output logic                          valid_out,
  output logic [DEPTH-1:0]              clip,
  output logic [DEPTH-1:0]              sticky,
  output logic [CNT_W-1:0]              clip_count
);

  logic clk;
  logic rst;

  assign clk = Util_Control_clock(ctrl);
  assign rst = Util_Control_reset(ctrl);

  logic [DEPTH-1:0][OUT_W-1:0] lane_out;
  logic [DEPTH-1:0]            lane_clip;
  logic                        any_clip;
  logic [DEPTH-1:0]            sticky_base;
  logic [CNT_W-1:0]            count_base;
  logic [CNT_W-1:0]            count_next;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    arith_narrow_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .in   (in[g]),
      .sign (sign),
      .out  (lane_out[g]),
      .clip (lane_clip[g])
    );
  end

  assign any_clip = |lane_clip;

  // Clear zeroes the history first so a clip in the same cycle still counts.
  always_comb begin
    sticky_base = clear ? '0 : sticky;
    count_base  = clear ? '0 : clip_count;
    count_next  = count_base;
    if (any_clip && (count_base != {CNT_W{1'b1}})) begin
      count_next = count_base + CNT_W'(1);
    end
  end

  // Output, sticky and counter registers; only accepted cycles move them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      valid_out  <= 1'b0;
      clip       <= '0;
      sticky     <= '0;
      clip_count <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        out        <= lane_out;
        clip       <= lane_clip;
        sticky     <= sticky_base | lane_clip;
        clip_count <= count_next;
      end else if (clear) begin
        sticky     <= '0;
        clip_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arith_narrow.sv
// Self-checking bench for arith_narrow: spec vectors, counter saturation,
// randomized traffic against an arithmetic reference model, reset mid-stream.
module tb_arith_narrow;
  import arith_narrow_pkg::*;

  logic clk = 1'b0;
  logic rst;
  Util_Control_T ctrl;
  logic [1:0][7:0] lanes_in;
  Arith_SignedUnsigned_T sign_in;
  logic valid_in;
  logic clear;

  logic [1:0][3:0] out_m;
  logic            valid_m;
  logic [1:0]      clip_m, sticky_m;
  logic [7:0]      count_m;

  logic [1:0][3:0] out_c;
  logic            valid_c;
  logic [1:0]      clip_c, sticky_c;
  logic [1:0]      count_c;

  logic [1:0][3:0] in_p;
  logic [1:0][3:0] out_p;
  logic            valid_p;
  logic [1:0]      clip_p, sticky_p;
  logic [7:0]      count_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign ctrl = '{clock: clk, reset: rst};
  assign in_p = {lanes_in[1][3:0], lanes_in[0][3:0]};

  arith_narrow #(.IN_W(8), .OUT_W(4), .DEPTH(2), .CNT_W(8)) dut (
    .ctrl(ctrl), .in(lanes_in), .sign(sign_in), .valid_in(valid_in), .clear(clear),
    .out(out_m), .valid_out(valid_m), .clip(clip_m), .sticky(sticky_m), .clip_count(count_m)
  );

  arith_narrow #(.IN_W(8), .OUT_W(4), .DEPTH(2), .CNT_W(2)) dut_cnt2 (
    .ctrl(ctrl), .in(lanes_in), .sign(sign_in), .valid_in(valid_in), .clear(clear),
    .out(out_c), .valid_out(valid_c), .clip(clip_c), .sticky(sticky_c), .clip_count(count_c)
  );

  arith_narrow #(.IN_W(4), .OUT_W(4), .DEPTH(2), .CNT_W(8)) dut_pass (
    .ctrl(ctrl), .in(in_p), .sign(sign_in), .valid_in(valid_in), .clear(clear),
    .out(out_p), .valid_out(valid_p), .clip(clip_p), .sticky(sticky_p), .clip_count(count_p)
  );

  // Reference model state
  typedef struct { logic [3:0] res; logic clip; } narrow_t;
  logic [3:0] m_out [2];
  logic [1:0] m_clip, m_sticky;
  logic       m_valid;
  int         m_cnt, m_cnt2;
  logic [7:0] m_out_p;

  function automatic narrow_t refNarrow(input logic [7:0] v, input logic s);
    narrow_t r;
    int x, lo, hi;
    if (s) begin
      x = int'($signed(v)); lo = -8; hi = 7;
    end else begin
      x = int'(v); lo = 0; hi = 15;
    end
    r.clip = (x > hi) || (x < lo);
    if (x > hi) x = hi;
    else if (x < lo) x = lo;
    r.res = x[3:0];
    return r;
  endfunction

  task automatic modelStep(input logic r, input logic v, input logic c, input logic s,
                           input logic [7:0] a, input logic [7:0] b);
    narrow_t n0, n1;
    int base;
    if (r) begin
      m_out[0] = 0; m_out[1] = 0; m_clip = 0; m_sticky = 0;
      m_valid = 0; m_cnt = 0; m_cnt2 = 0; m_out_p = 0;
    end else begin
      m_valid = v;
      if (v) begin
        n0 = refNarrow(a, s);
        n1 = refNarrow(b, s);
        m_out[0] = n0.res; m_out[1] = n1.res;
        m_clip = {n1.clip, n0.clip};
        m_sticky = (c ? 2'b00 : m_sticky) | m_clip;
        base = c ? 0 : m_cnt;
        m_cnt = (m_clip != 0) ? ((base + 1 > 255) ? 255 : base + 1) : base;
        base = c ? 0 : m_cnt2;
        m_cnt2 = (m_clip != 0) ? ((base + 1 > 3) ? 3 : base + 1) : base;
        m_out_p = {b[3:0], a[3:0]};
      end else if (c) begin
        m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
      end
    end
  endtask

  // Drive inputs, advance one edge, update the model, settle before checks.
  task automatic applyStimulus(input logic r, input logic v, input logic c, input logic s,
                               input logic [7:0] a, input logic [7:0] b);
    rst = r; valid_in = v; clear = c;
    sign_in = s ? ARITH_SIGNED : ARITH_UNSIGNED;
    lanes_in[0] = a; lanes_in[1] = b;
    @(posedge clk);
    modelStep(r, v, c, s, a, b);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eo0, input logic [3:0] eo1,
                             input logic [1:0] ec, input logic [1:0] es, input logic ev,
                             input int ecnt, input int ecnt2);
    checkField({tag, ".out0"},    32'(out_m[0]), 32'(eo0));
    checkField({tag, ".out1"},    32'(out_m[1]), 32'(eo1));
    checkField({tag, ".clip"},    32'(clip_m),   32'(ec));
    checkField({tag, ".sticky"},  32'(sticky_m), 32'(es));
    checkField({tag, ".valid"},   32'(valid_m),  32'(ev));
    checkField({tag, ".count"},   32'(count_m),  32'(ecnt));
    checkField({tag, ".count2"},  32'(count_c),  32'(ecnt2));
  endtask

  typedef struct {
    logic v, c, s;
    logic [7:0] a, b;
    logic [3:0] o0, o1;
    logic [1:0] cl, st;
    logic vo;
    int cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cnt2_seq [5];
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'hF9, 4'h7, 4'h9, 2'b01, 2'b01, 1'b1, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h05, 4'h8, 4'h5, 2'b01, 2'b01, 1'b1, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'hF8, 8'h07, 4'h8, 4'h7, 2'b00, 2'b01, 1'b1, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h0A, 8'h10, 4'hA, 4'hF, 2'b10, 2'b11, 1'b1, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 4'hF, 4'h0, 2'b01, 2'b01, 1'b1, 1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h55, 4'hF, 4'h0, 2'b01, 2'b00, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h0F, 4'hF, 4'hF, 2'b01, 2'b01, 1'b1, 1};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h0F, 4'hF, 4'h7, 2'b10, 2'b11, 1'b1, 2};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h03, 4'h0, 4'h3, 2'b00, 2'b00, 1'b1, 0};
    cnt2_seq = '{1, 2, 3, 3, 3};

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Spec vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].v, vecs[i].c, vecs[i].s, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].o0, vecs[i].o1, vecs[i].cl,
                  vecs[i].st, vecs[i].vo, vecs[i].cnt, vecs[i].cnt);
    end

    // Narrow counter saturates at 3 and holds
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h7F);
      checkField($sformatf("sat2_%0d", i), 32'(count_c), 32'(cnt2_seq[i]));
      checkField($sformatf("cnt8_%0d", i), 32'(count_m), 32'(i + 1));
    end

    // Wide counter saturates at 255 and never wraps
    for (int i = 5; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
      if (i == 254) checkField("cnt8_255", 32'(count_m), 32'd255);
    end
    checkField("cnt8_hold", 32'(count_m), 32'd255);
    checkField("cnt2_hold", 32'(count_c), 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, v, c, s;
      logic [7:0] a, b;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0);
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom);
      applyStimulus(r, v, c, s, a, b);
      checkOutput($sformatf("rnd%0d", i), m_out[0], m_out[1], m_clip, m_sticky,
                  m_valid, m_cnt, m_cnt2);
      checkField($sformatf("rnd%0d.pass_out", i), 32'(out_p), 32'(m_out_p));
      checkField($sformatf("rnd%0d.pass_clip", i), 32'(clip_p), 32'd0);
    end

    // Reset in the middle of a valid stream discards everything
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h80);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h80);
    checkOutput("midrst", 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h80);
      checkOutput($sformatf("idle%0d", i), 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 0, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h80);
    checkOutput("first", 4'h7, 4'h8, 2'b11, 2'b11, 1'b1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
